// File: rtl/display_scan_mux.sv
// rtl/display_scan_mux.sv - four-digit 7-segment scan multiplexer with blanking, blink, PWM and dead time
module display_scan_mux #(
    parameter int         CLK_HZ      = 50_000_000,
    parameter int         REFRESH_HZ  = 1000,
    parameter int         BLINK_HZ    = 2,
    parameter int         DEAD        = 4,
    parameter logic [6:0] ZERO_PAT    = 7'h3F,
    parameter bit         AN_ACT_LOW  = 1'b1,
    parameter bit         SEG_ACT_LOW = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic [6:0] i_dig_un,
    input  logic [6:0] i_dig_de,
    input  logic [6:0] i_dig_ce,
    input  logic [6:0] i_dig_mi,
    input  logic       i_blank_lz,
    input  logic [3:0] i_blink_mask,
    input  logic [3:0] i_bright,
    output logic [3:0] o_an,
    output logic [6:0] o_seg,
    output logic [1:0] o_digit_idx,
    output logic       o_frame_tick
);
    localparam int DIV      = CLK_HZ / REFRESH_HZ;
    localparam int BLINK_TC = CLK_HZ / (2 * BLINK_HZ);
    localparam int SLOT     = DIV - DEAD;
    localparam int CW       = $clog2(DIV);
    localparam int BW       = $clog2(BLINK_TC);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TC - 1);
    localparam logic [3:0]    AN_OFF    = AN_ACT_LOW ? 4'hF : 4'h0;
    localparam logic [6:0]    SEG_OFF   = SEG_ACT_LOW ? 7'h7F : 7'h00;

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [BW-1:0] r_blink_cnt;
    logic          r_phase;
    logic          r_wrapped;
    logic [6:0]    r_snap_un, r_snap_de, r_snap_ce, r_snap_mi;
    logic          r_snap_lz;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic [1:0]    r_digit_idx;
    logic          r_frame_tick;

    logic          w_slot_end, w_wrap, w_lit;
    logic          w_lz_mi, w_lz_ce, w_lz_de;
    logic [3:0]    w_lz;
    logic [3:0]    w_an_on;
    logic [6:0]    w_pat;
    int            w_width, w_pos;

    always_comb begin
        w_slot_end = (r_cnt == CNT_MAX);
        w_wrap     = i_en && w_slot_end && (r_idx == 2'd3);
        // Only a run of zeros starting at thousands is blanked; units always shows.
        w_lz_mi    = r_snap_lz && (r_snap_mi == ZERO_PAT);
        w_lz_ce    = w_lz_mi && (r_snap_ce == ZERO_PAT);
        w_lz_de    = w_lz_ce && (r_snap_de == ZERO_PAT);
        w_lz       = {w_lz_mi, w_lz_ce, w_lz_de, 1'b0};
        case (r_idx)
            2'd0:    w_pat = r_snap_un;
            2'd1:    w_pat = r_snap_de;
            2'd2:    w_pat = r_snap_ce;
            default: w_pat = r_snap_mi;
        endcase
        w_an_on = 4'b0001 << r_idx;
        w_width = ((int'(i_bright) + 1) * SLOT) >> 4;
        w_pos   = int'(r_cnt) - DEAD;
        w_lit   = i_en && (w_pos >= 0) && (w_pos < w_width) && !w_lz[r_idx]
                  && !(i_blink_mask[r_idx] && r_phase);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt       <= '0;
            r_idx       <= 2'd0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
            r_wrapped   <= 1'b0;
        end else if (!i_en) begin
            r_cnt       <= '0;
            r_idx       <= 2'd0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
            r_wrapped   <= 1'b0;
        end else begin
            r_cnt     <= w_slot_end ? '0 : r_cnt + 1'b1;
            r_idx     <= w_slot_end ? r_idx + 2'd1 : r_idx;
            r_wrapped <= w_wrap;
            if (r_blink_cnt == BLINK_MAX) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    // Patterns are captured once per frame so a digit never tears mid-scan.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_snap_un <= 7'h00;
            r_snap_de <= 7'h00;
            r_snap_ce <= 7'h00;
            r_snap_mi <= 7'h00;
            r_snap_lz <= 1'b0;
        end else if (w_wrap) begin
            r_snap_un <= i_dig_un;
            r_snap_de <= i_dig_de;
            r_snap_ce <= i_dig_ce;
            r_snap_mi <= i_dig_mi;
            r_snap_lz <= i_blank_lz;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_an         <= AN_OFF;
            r_seg        <= SEG_OFF;
            r_digit_idx  <= 2'd0;
            r_frame_tick <= 1'b0;
        end else begin
            r_an         <= w_lit ? (AN_ACT_LOW ? ~w_an_on : w_an_on) : AN_OFF;
            r_seg        <= w_lit ? (SEG_ACT_LOW ? ~w_pat : w_pat) : SEG_OFF;
            r_digit_idx  <= r_idx;
            r_frame_tick <= i_en && r_wrapped;
        end
    end

    assign o_an         = r_an;
    assign o_seg        = r_seg;
    assign o_digit_idx  = r_digit_idx;
    assign o_frame_tick = r_frame_tick;
endmodule

// File: tb/tb_display_scan_mux.sv
// tb/tb_display_scan_mux.sv - self-checking bench for display_scan_mux with a time-based reference model
module tb_display_scan_mux;
    localparam int DIV   = 16;
    localparam int DEAD  = 2;
    localparam int FRAME = 64;
    localparam int PHASE = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [6:0] dig_un = 7'h00, dig_de = 7'h00, dig_ce = 7'h00, dig_mi = 7'h00;
    logic       blank_lz = 1'b0;
    logic [3:0] blink_mask = 4'h0;
    logic [3:0] bright = 4'hF;
    logic [3:0] o_an;
    logic [6:0] o_seg;
    logic [1:0] o_digit_idx;
    logic       o_frame_tick;

    int checks = 0;
    int errors = 0;

    display_scan_mux #(
        .CLK_HZ(1600), .REFRESH_HZ(100), .BLINK_HZ(25), .DEAD(DEAD),
        .ZERO_PAT(7'h3F), .AN_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
        .i_dig_un(dig_un), .i_dig_de(dig_de), .i_dig_ce(dig_ce), .i_dig_mi(dig_mi),
        .i_blank_lz(blank_lz), .i_blink_mask(blink_mask), .i_bright(bright),
        .o_an(o_an), .o_seg(o_seg), .o_digit_idx(o_digit_idx), .o_frame_tick(o_frame_tick)
    );

    always #5 clk = ~clk;

    // Reference model: m_t counts cycles since scanning started; slot, digit and
    // blink phase all follow from it by division.
    int         m_t;
    logic [6:0] m_snap [4];
    logic       m_snap_lz;
    int         m_pos, m_idx, m_phase, m_width;
    logic [3:0] m_blank;
    logic       m_lit;
    logic [3:0] m_an;
    logic [6:0] m_seg;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic [1:0] exp_idx;
    logic       exp_ft;

    always_comb begin
        m_pos      = (m_t % DIV) - DEAD;
        m_idx      = (m_t / DIV) % 4;
        m_phase    = (m_t / PHASE) % 2;
        m_width    = ((int'(bright) + 1) * (DIV - DEAD)) / 16;
        m_blank[3] = m_snap_lz && (m_snap[3] == 7'h3F);
        m_blank[2] = m_blank[3] && (m_snap[2] == 7'h3F);
        m_blank[1] = m_blank[2] && (m_snap[1] == 7'h3F);
        m_blank[0] = 1'b0;
        m_lit      = en && m_pos >= 0 && m_pos < m_width && !m_blank[m_idx]
                     && !(blink_mask[m_idx] && m_phase == 1);
        m_an       = m_lit ? ~(4'b0001 << m_idx) : 4'hF;
        m_seg      = m_lit ? ~m_snap[m_idx] : 7'h7F;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t       <= 0;
            m_snap_lz <= 1'b0;
            for (int i = 0; i < 4; i++) m_snap[i] <= 7'h00;
            exp_an    <= 4'hF;
            exp_seg   <= 7'h7F;
            exp_idx   <= 2'd0;
            exp_ft    <= 1'b0;
        end else begin
            exp_an  <= m_an;
            exp_seg <= m_seg;
            exp_idx <= 2'(m_idx);
            exp_ft  <= en && m_t > 0 && (m_t % FRAME) == 0;
            m_t     <= en ? m_t + 1 : 0;
            if (en && (m_t % FRAME) == FRAME - 1) begin
                m_snap[0] <= dig_un;
                m_snap[1] <= dig_de;
                m_snap[2] <= dig_ce;
                m_snap[3] <= dig_mi;
                m_snap_lz <= blank_lz;
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            en = 1'($urandom); dig_un = 7'($urandom); bright = 4'($urandom);
            blink_mask = 4'($urandom); blank_lz = 1'($urandom);
            checks++;
            if (o_an !== 4'hF || o_seg !== 7'h7F || o_digit_idx !== 2'd0 || o_frame_tick !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold an=%h seg=%h idx=%0d ft=%b need an=F seg=7F idx=0 ft=0",
                         o_an, o_seg, o_digit_idx, o_frame_tick);
            end
        end
        en = 1'b1; blink_mask = 4'h0; bright = 4'hF; blank_lz = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (o_an !== 4'hF || o_seg !== 7'h7F || o_digit_idx !== 2'd0 || o_frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_release an=%h seg=%h idx=%0d ft=%b need an=F seg=7F idx=0 ft=0",
                     o_an, o_seg, o_digit_idx, o_frame_tick);
        end
    endtask

    task automatic test_scan();
        int last_ft = -1;
        dig_un = 7'h06; dig_de = 7'h5B; dig_ce = 7'h4F; dig_mi = 7'h66;
        for (int c = 0; c < 320; c++) begin
            if (c == 200) begin
                dig_un = 7'($urandom); dig_de = 7'($urandom);
                dig_ce = 7'($urandom); dig_mi = 7'($urandom);
            end
            @(negedge clk);
            checks++;
            if (o_an !== exp_an || o_seg !== exp_seg || o_digit_idx !== exp_idx || o_frame_tick !== exp_ft) begin
                errors++;
                $display("FAIL scan c=%0d an=%h seg=%h idx=%0d ft=%b need an=%h seg=%h idx=%0d ft=%b",
                         c, o_an, o_seg, o_digit_idx, o_frame_tick, exp_an, exp_seg, exp_idx, exp_ft);
            end
            if (o_frame_tick) begin
                if (last_ft >= 0) begin
                    checks++;
                    if (c - last_ft != FRAME) begin
                        errors++;
                        $display("FAIL frame_period got=%0d need=%0d", c - last_ft, FRAME);
                    end
                end
                last_ft = c;
            end
        end
    endtask

    task automatic test_lz();
        int lit_mi, lit_de;
        blank_lz = 1'b1; bright = 4'hF;
        for (int pass = 0; pass < 2; pass++) begin
            dig_mi = 7'h3F; dig_un = 7'($urandom);
            dig_ce = (pass == 0) ? 7'h3F : 7'h06;
            dig_de = (pass == 0) ? 7'h06 : 7'h3F;
            lit_mi = 0; lit_de = 0;
            for (int c = 0; c < 2 * FRAME + 128; c++) begin
                @(negedge clk);
                checks++;
                if (o_an !== exp_an || o_seg !== exp_seg || o_digit_idx !== exp_idx || o_frame_tick !== exp_ft) begin
                    errors++;
                    $display("FAIL lz c=%0d an=%h seg=%h idx=%0d need an=%h seg=%h idx=%0d",
                             c, o_an, o_seg, o_digit_idx, exp_an, exp_seg, exp_idx);
                end
                if (c >= 2 * FRAME) begin
                    if (o_an == 4'h7) lit_mi++;
                    if (o_an == 4'hD) lit_de++;
                end
            end
            checks++;
            if (lit_mi != 0 || lit_de != 28) begin
                errors++;
                $display("FAIL lz_counts pass=%0d thousands_lit=%0d need 0 tens_lit=%0d need 28",
                         pass, lit_mi, lit_de);
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_bright();
        int lit;
        logic [3:0] levels [3] = '{4'd0, 4'd7, 4'd15};
        int         expect_lit [3] = '{0, 28, 56};
        for (int k = 0; k < 3; k++) begin
            bright = levels[k];
            @(negedge clk);
            lit = 0;
            for (int c = 0; c < FRAME; c++) begin
                @(negedge clk);
                if (o_an != 4'hF) lit++;
                checks++;
                if (o_an !== exp_an || o_seg !== exp_seg) begin
                    errors++;
                    $display("FAIL bright b=%0d an=%h seg=%h need an=%h seg=%h",
                             bright, o_an, o_seg, exp_an, exp_seg);
                end
            end
            checks++;
            if (lit != expect_lit[k]) begin
                errors++;
                $display("FAIL bright_width b=%0d lit_per_frame=%0d need=%0d", bright, lit, expect_lit[k]);
            end
        end
        for (int c = 0; c < 200; c++) begin
            if (c % 9 == 0) bright = 4'($urandom);
            @(negedge clk);
            checks++;
            if (o_an !== exp_an || o_seg !== exp_seg) begin
                errors++;
                $display("FAIL bright_rand b=%0d an=%h seg=%h need an=%h seg=%h",
                         bright, o_an, o_seg, exp_an, exp_seg);
            end
        end
        bright = 4'hF;
    endtask

    task automatic test_blink();
        int lit [4];
        // Frame is two blink phases long, so units and tens always scan in the
        // visible phase while hundreds and thousands always scan in the hidden one.
        logic [3:0] masks [3] = '{4'b0001, 4'b0100, 4'b1010};
        logic [3:0] pat;
        for (int k = 0; k < 3; k++) begin
            blink_mask = masks[k];
            pat = masks[k];
            @(negedge clk);
            for (int d = 0; d < 4; d++) lit[d] = 0;
            for (int c = 0; c < 2 * FRAME; c++) begin
                @(negedge clk);
                for (int d = 0; d < 4; d++) if (o_an == ~(4'b0001 << d)) lit[d]++;
                checks++;
                if (o_an !== exp_an || o_seg !== exp_seg) begin
                    errors++;
                    $display("FAIL blink mask=%b an=%h seg=%h need an=%h seg=%h",
                             blink_mask, o_an, o_seg, exp_an, exp_seg);
                end
            end
            for (int d = 0; d < 4; d++) begin
                checks++;
                if (lit[d] != ((pat[d] && d >= 2) ? 0 : 28)) begin
                    errors++;
                    $display("FAIL blink_count mask=%b digit=%0d lit=%0d need=%0d",
                             pat, d, lit[d], (pat[d] && d >= 2) ? 0 : 28);
                end
            end
        end
        for (int c = 0; c < 256; c++) begin
            if (c % 40 == 0) blink_mask = 4'($urandom);
            @(negedge clk);
            checks++;
            if (o_an !== exp_an || o_seg !== exp_seg) begin
                errors++;
                $display("FAIL blink_rand mask=%b an=%h seg=%h need an=%h seg=%h",
                         blink_mask, o_an, o_seg, exp_an, exp_seg);
            end
        end
        blink_mask = 4'h0;
    endtask

    task automatic test_snapshot_en();
        logic [6:0] old_un, new_un;
        int n;
        bit found;
        old_un = 7'h5B; new_un = 7'h6D;
        dig_un = old_un;
        repeat (2 * FRAME) @(negedge clk);
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (o_digit_idx == 2'd1) found = 1;
        end
        dig_un = new_un;
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (o_frame_tick) found = 1;
            else if (o_an == 4'hE) begin
                checks++;
                if (o_seg !== ~old_un) begin
                    errors++;
                    $display("FAIL snap_hold seg=%h need=%h", o_seg, ~old_un);
                end
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL snap_frame_tick got=timeout need=pulse");
        end
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (o_an == 4'hE) found = 1;
        end
        checks++;
        if (!found || o_seg !== ~new_un) begin
            errors++;
            $display("FAIL snap_update found=%b seg=%h need=%h", found, o_seg, ~new_un);
        end
        repeat (5) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        checks++;
        if (o_an !== 4'hF || o_seg !== 7'h7F || o_frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL en_off an=%h seg=%h ft=%b need an=F seg=7F ft=0", o_an, o_seg, o_frame_tick);
        end
        repeat (7) @(negedge clk);
        en = 1'b1;
        n = 0;
        found = 0;
        for (int c = 1; c <= 20 && !found; c++) begin
            @(negedge clk);
            if (o_an != 4'hF) begin found = 1; n = c; end
        end
        checks++;
        if (!found || n != DEAD + 1 || o_an !== 4'hE) begin
            errors++;
            $display("FAIL reenable first_lit_cycle=%0d an=%h need cycle=%0d an=E", n, o_an, DEAD + 1);
        end
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (o_an !== 4'hF || o_seg !== 7'h7F || o_digit_idx !== 2'd0) begin
            errors++;
            $display("FAIL async_reset an=%h seg=%h idx=%0d need an=F seg=7F idx=0", o_an, o_seg, o_digit_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dig_un = 7'($urandom); dig_de = 7'($urandom);
        for (int c = 0; c < 3 * FRAME; c++) begin
            @(negedge clk);
            checks++;
            if (o_an !== exp_an || o_seg !== exp_seg || o_digit_idx !== exp_idx || o_frame_tick !== exp_ft) begin
                errors++;
                $display("FAIL post_reset c=%0d an=%h seg=%h idx=%0d ft=%b need an=%h seg=%h idx=%0d ft=%b",
                         c, o_an, o_seg, o_digit_idx, o_frame_tick, exp_an, exp_seg, exp_idx, exp_ft);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_lz();
        test_bright();
        test_blink();
        test_snapshot_en();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
